// File: rtl/multicore_run_controller_if.sv
// Memory-port bundle between the run controller, the UART memory interfaces,
// the processor cores and the data/instruction memories.
//   uart_dmem_* / proc_dmem_* : data-port sources (UART side, processor side)
//   uart_imem_* / proc_imem_* : instruction-port sources
//   dmem_* / imem_*           : multiplexed ports toward the memories
// The controller uses the master modport, which drives the multiplexed
// ports. The slave modport is the view from the sources and memories.
interface multicore_run_controller_if #(
    parameter int DATA_MEM_WIDTH      = 24,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_MEM_ADDR_WIDTH  = 8
);
    logic                           uart_dmem_wrEn;
    logic [DATA_MEM_ADDR_WIDTH-1:0] uart_dmem_addr;
    logic [DATA_MEM_WIDTH-1:0]      uart_dmem_data;
    logic                           proc_dmem_wrEn;
    logic [DATA_MEM_ADDR_WIDTH-1:0] proc_dmem_addr;
    logic [DATA_MEM_WIDTH-1:0]      proc_dmem_data;
    logic                           uart_imem_wrEn;
    logic [INS_MEM_ADDR_WIDTH-1:0]  uart_imem_addr;
    logic [INS_MEM_ADDR_WIDTH-1:0]  proc_imem_addr;
    logic                           dmem_wrEn;
    logic [DATA_MEM_ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_MEM_WIDTH-1:0]      dmem_data;
    logic                           imem_wrEn;
    logic [INS_MEM_ADDR_WIDTH-1:0]  imem_addr;

    modport master (
        input  uart_dmem_wrEn, uart_dmem_addr, uart_dmem_data,
        input  proc_dmem_wrEn, proc_dmem_addr, proc_dmem_data,
        input  uart_imem_wrEn, uart_imem_addr, proc_imem_addr,
        output dmem_wrEn, dmem_addr, dmem_data,
        output imem_wrEn, imem_addr
    );

    modport slave (
        output uart_dmem_wrEn, uart_dmem_addr, uart_dmem_data,
        output proc_dmem_wrEn, proc_dmem_addr, proc_dmem_data,
        output uart_imem_wrEn, uart_imem_addr, proc_imem_addr,
        input  dmem_wrEn, dmem_addr, dmem_data,
        input  imem_wrEn, imem_addr
    );
endinterface

// File: rtl/multicore_run_controller.sv
// Run sequencer and memory-port arbiter for the multicore matrix processor.
// Steps IDLE -> RX_IMEM -> RX_DMEM -> EXECUTE -> TX_DMEM -> FINISH (optionally
// looping back to RX_DMEM), with an ERROR state on execution timeout.
// Ports:
//   clk, rstN          : clock, asynchronous active-low reset
//   startN             : active-low start level (falling edge starts a run)
//   loop_mode, abort   : repeat-run enable, synchronous abort to IDLE
//   ins_received, dmem_received, dmem_transmitted : UART completion pulses
//   rx_new_byte        : UART byte strobe, gated to new_ins_byte/new_data_byte
//   core_done          : per-core done levels
//   mem                : memory-port bundle (master view)
//   process_start      : one-cycle core start pulse
//   dmem_tx_startN     : active-low one-cycle transmit start
//   state, timeout_err, cycle_count, run_count : status
module multicore_run_controller #(
    parameter int CORE_COUNT          = 2,
    parameter int REG_WIDTH           = 12,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_MEM_ADDR_WIDTH  = 8,
    parameter int CYCLE_CNT_WIDTH     = 26,
    parameter int TIMEOUT_CYCLES      = 2**24
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       startN,
    input  logic                       loop_mode,
    input  logic                       abort,
    input  logic                       ins_received,
    input  logic                       dmem_received,
    input  logic                       dmem_transmitted,
    input  logic                       rx_new_byte,
    input  logic [CORE_COUNT-1:0]      core_done,
    multicore_run_controller_if.master mem,
    output logic                       new_ins_byte,
    output logic                       new_data_byte,
    output logic                       process_start,
    output logic                       dmem_tx_startN,
    output logic [2:0]                 state,
    output logic                       timeout_err,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count,
    output logic [7:0]                 run_count
);
    localparam int DATA_MEM_WIDTH = CORE_COUNT * REG_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX_IMEM = 3'd1;
    localparam logic [2:0] S_RX_DMEM = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_TX_DMEM = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [CYCLE_CNT_WIDTH-1:0] TO_LAST = CYCLE_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    function automatic logic [CYCLE_CNT_WIDTH-1:0] sat_inc(input logic [CYCLE_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0]            next_state;
    logic                  start_held;   // 1 = startN was low last cycle (or in reset)
    logic                  start_fall;
    logic [CORE_COUNT-1:0] done_seen;
    logic [CORE_COUNT-1:0] done_now;
    logic                  all_done;
    logic                  timeout_hit;
    logic                  exec_entry;
    logic                  tx_entry;

    // Presetting start_held to 1 means a startN already low at reset release
    // is treated as an old level, so only a genuine high-to-low transition starts.
    assign start_fall = ~start_held & ~startN;

    // process_start marks the first EXECUTE cycle; done levels seen there are
    // left over from the previous run and must not count.
    assign done_now    = process_start ? '0 : core_done;
    assign all_done    = &(done_seen | done_now);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start_fall)       next_state = S_RX_IMEM;
                S_RX_IMEM: if (ins_received)     next_state = S_RX_DMEM;
                S_RX_DMEM: if (dmem_received)    next_state = S_EXECUTE;
                S_EXECUTE: begin
                    // done takes precedence over a coincident timeout
                    if (all_done)                next_state = S_TX_DMEM;
                    else if (timeout_hit)        next_state = S_ERROR;
                end
                S_TX_DMEM: if (dmem_transmitted) next_state = S_FINISH;
                S_FINISH: begin
                    if (loop_mode)               next_state = S_RX_DMEM;
                    else if (start_fall)         next_state = S_RX_IMEM;
                end
                S_ERROR:                         next_state = S_ERROR;
                default:                         next_state = S_IDLE;
            endcase
        end
    end

    assign exec_entry = (next_state == S_EXECUTE) && (state != S_EXECUTE);
    assign tx_entry   = (next_state == S_TX_DMEM) && (state != S_TX_DMEM);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state          <= S_IDLE;
            start_held     <= 1'b1;
            process_start  <= 1'b0;
            dmem_tx_startN <= 1'b1;
            timeout_err    <= 1'b0;
            cycle_count    <= '0;
            run_count      <= '0;
            done_seen      <= '0;
        end else begin
            state          <= next_state;
            start_held     <= ~startN;
            process_start  <= exec_entry;
            dmem_tx_startN <= ~tx_entry;

            if (abort)
                timeout_err <= 1'b0;
            else if (state == S_EXECUTE && next_state == S_ERROR)
                timeout_err <= 1'b1;

            if (exec_entry)
                cycle_count <= '0;
            else if (state == S_EXECUTE)
                cycle_count <= sat_inc(cycle_count);

            if (exec_entry)
                done_seen <= '0;
            else if (state == S_EXECUTE)
                done_seen <= done_seen | done_now;

            if (state == S_TX_DMEM && next_state == S_FINISH)
                run_count <= run_count + 8'd1;
        end
    end

    always_comb begin
        mem.dmem_wrEn = 1'b0;
        mem.dmem_addr = DATA_MEM_ADDR_WIDTH'(0);
        mem.dmem_data = DATA_MEM_WIDTH'(0);
        mem.imem_wrEn = 1'b0;
        mem.imem_addr = INS_MEM_ADDR_WIDTH'(0);
        new_ins_byte  = 1'b0;
        new_data_byte = 1'b0;
        case (state)
            S_RX_IMEM: begin
                mem.imem_wrEn = mem.uart_imem_wrEn;
                mem.imem_addr = mem.uart_imem_addr;
                new_ins_byte  = rx_new_byte;
            end
            S_RX_DMEM, S_TX_DMEM: begin
                mem.dmem_wrEn = mem.uart_dmem_wrEn;
                mem.dmem_addr = mem.uart_dmem_addr;
                mem.dmem_data = mem.uart_dmem_data;
                new_data_byte = (state == S_RX_DMEM) ? rx_new_byte : 1'b0;
            end
            S_EXECUTE: begin
                mem.dmem_wrEn = mem.proc_dmem_wrEn;
                mem.dmem_addr = mem.proc_dmem_addr;
                mem.dmem_data = mem.proc_dmem_data;
                mem.imem_addr = mem.proc_imem_addr;
            end
            default: ;
        endcase
    end
endmodule
